// File: rtl/iso_serial_ctl.sv
// iso_serial_ctl: serial control-link master for the isolator board.
// Shifts chip-select and hwcon bytes out and dir/chan/hwflag bytes in,
// generating sclk and srclk from registered state.
// Optional build macro: ISO_SERIAL_FLAG_FILTER_EN enables a two-frame
// glitch filter on the published hwflag field.
module iso_serial_ctl #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] cs_n_par,
   input  logic [7:0] hwcon_par,
   output logic [3:0] dir,
   output logic [3:0] chan,
   output logic [3:0] hwflag,
   output logic       frame_done,
   output logic       sclk,
   output logic       srclk,
   output logic       cs_n_ser,
   output logic       hwcon_ser,
   input  logic       dirchan_ser,
   input  logic       hwflag_ser
);

   if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
      $fatal(1, "iso_serial_ctl: CLK_DIV must be in 2..255");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      LATCH = 3'd3,
      GAP   = 3'd4
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic       phase, phase_n;     // 0: sclk low half, 1: sclk high half
   logic [2:0] bit_idx, bit_n;
   logic       cnt_last;

   logic       load_evt;           // capture parallel transmit bytes
   logic       tx_shift;           // advance transmit data to the next bit
   logic       sample;             // take one receive bit
   logic       publish;            // hand received fields to the outputs

   logic [7:0] tx_cs;
   logic [7:0] tx_hw;
   logic [7:0] rx_dirchan;
   // Only the low nibble of the hwflag byte is meaningful; after eight
   // shifts a 4-bit register holds exactly rx_hwflag[3:0].
   logic [3:0] rx_hwflag;

   assign cnt_last  = (cnt == DIV_LAST);
   assign cs_n_ser  = tx_cs[7];
   assign hwcon_ser = tx_hw[7];

   // Next-state, counter advance and per-cycle frame events
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      phase_n  = phase;
      bit_n    = bit_idx;
      load_evt = 1'b0;
      tx_shift = 1'b0;
      sample   = 1'b0;
      publish  = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = 8'd0;
            if (enable) state_n = LOAD;
         end
         LOAD: begin
            load_evt = 1'b1;
            state_n  = SHIFT;
            cnt_n    = 8'd0;
            phase_n  = 1'b0;
            bit_n    = 3'd0;
         end
         SHIFT: begin
            if (cnt_last) begin
               cnt_n = 8'd0;
               if (!phase) begin
                  phase_n = 1'b1;
               end else begin
                  sample  = 1'b1;
                  phase_n = 1'b0;
                  if (bit_idx == 3'd7) begin
                     state_n = LATCH;
                  end else begin
                     bit_n    = bit_idx + 3'd1;
                     tx_shift = 1'b1;
                  end
               end
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         LATCH: begin
            if (cnt_last) begin
               cnt_n   = 8'd0;
               state_n = GAP;
               publish = 1'b1;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         GAP: begin
            if (cnt_last) begin
               cnt_n   = 8'd0;
               state_n = enable ? LOAD : IDLE;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 8'd0;
         end
      endcase
   end

   // Control registers; sclk/srclk are registered from next-state so
   // they come straight from flops and line up with the state they mark
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         phase   <= 1'b0;
         bit_idx <= 3'd0;
         sclk    <= 1'b0;
         srclk   <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         phase   <= phase_n;
         bit_idx <= bit_n;
         sclk    <= (state_n == SHIFT) && phase_n;
         srclk   <= (state_n == LATCH);
      end
   end

   // Transmit shift registers, MSB first; data moves only at the start
   // of a low phase, so the isolator sees it stable on the rising edge
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_cs <= 8'hFF;
         tx_hw <= 8'h00;
      end else if (load_evt) begin
         tx_cs <= cs_n_par;
         tx_hw <= hwcon_par;
      end else if (tx_shift) begin
         tx_cs <= {tx_cs[6:0], 1'b1};
         tx_hw <= {tx_hw[6:0], 1'b0};
      end
   end

   // Receive shift registers, sampled on the last cycle of each high phase
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_dirchan <= 8'h00;
         rx_hwflag  <= 4'h0;
      end else if (sample) begin
         rx_dirchan <= {rx_dirchan[6:0], dirchan_ser};
         rx_hwflag  <= {rx_hwflag[2:0], hwflag_ser};
      end
   end

`ifdef ISO_SERIAL_FLAG_FILTER_EN
   logic [3:0] flag_hist;

   // Publish received fields; hwflag only moves once two frames agree
   always_ff @(posedge clk) begin
      if (reset) begin
         dir        <= 4'h0;
         chan       <= 4'h0;
         hwflag     <= 4'h0;
         flag_hist  <= 4'h0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= publish;
         if (publish) begin
            dir       <= rx_dirchan[3:0];
            chan      <= rx_dirchan[7:4];
            flag_hist <= rx_hwflag;
            if (rx_hwflag == flag_hist) hwflag <= rx_hwflag;
         end
      end
   end
`else
   // Publish received fields every frame
   always_ff @(posedge clk) begin
      if (reset) begin
         dir        <= 4'h0;
         chan       <= 4'h0;
         hwflag     <= 4'h0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= publish;
         if (publish) begin
            dir    <= rx_dirchan[3:0];
            chan   <= rx_dirchan[7:4];
            hwflag <= rx_hwflag;
         end
      end
   end
`endif

endmodule

// File: tb/tb_iso_serial_ctl.sv
// Testbench for iso_serial_ctl: isolator shift-register model, frame-level
// scoreboard, vector table, directed corner sequences and random frames.
module tb_iso_serial_ctl;

   localparam int D        = 4;
   localparam int FRAME    = 1 + 18 * D;
   localparam int REL_TO_FD = 2 + 17 * D;   // negedges from reset release to frame_done

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] cs_n_par = 8'hFE;
   logic [7:0] hwcon_par = 8'h05;
   logic [3:0] dir, chan, hwflag;
   logic       frame_done, sclk, srclk, cs_n_ser, hwcon_ser;
   logic       dirchan_ser, hwflag_ser;

   int vectors = 0;
   int miscompares = 0;

   iso_serial_ctl #(.CLK_DIV(D)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cs_n_par(cs_n_par), .hwcon_par(hwcon_par),
      .dir(dir), .chan(chan), .hwflag(hwflag), .frame_done(frame_done),
      .sclk(sclk), .srclk(srclk), .cs_n_ser(cs_n_ser), .hwcon_ser(hwcon_ser),
      .dirchan_ser(dirchan_ser), .hwflag_ser(hwflag_ser)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- isolator model (595 deserializers, 165 serializers)
   logic [3:0] iso_dir = 4'h0, iso_chan = 4'h0, iso_flag = 4'h0;
   logic [7:0] des_cs = 8'h00, des_hw = 8'h00;
   logic [7:0] lat_cs = 8'h00, lat_hw = 8'h00;
   logic [7:0] ser_dc = 8'h00, ser_fl = 8'h00;

   always @(posedge sclk) begin
      des_cs <= {des_cs[6:0], cs_n_ser};
      des_hw <= {des_hw[6:0], hwcon_ser};
   end
   always @(posedge srclk) begin
      lat_cs <= des_cs;
      lat_hw <= des_hw;
   end
   always @(posedge srclk or negedge sclk) begin
      if (srclk) begin
         ser_dc <= {iso_chan, iso_dir};
         ser_fl <= {4'h0, iso_flag};
      end else begin
         ser_dc <= {ser_dc[6:0], 1'b0};
         ser_fl <= {ser_fl[6:0], 1'b0};
      end
   end
   assign dirchan_ser = ser_dc[7];
   assign hwflag_ser  = ser_fl[7];

   // ---------------- frame-level reference model
   // Each srclk rise snapshots the isolator; a frame publishes the snapshot
   // taken at the srclk before its own.
   logic [11:0] snap = 12'h000, exp_pub = 12'h000;   // {chan, dir, flag}
   logic [3:0]  hist = 4'h0, hw_exp = 4'h0;

   always @(posedge srclk) begin
      exp_pub <= snap;
      snap    <= {iso_chan, iso_dir, iso_flag};
   end

   always @(negedge clk) begin
      if (reset) begin
         hist   = 4'h0;
         hw_exp = 4'h0;
      end else begin
         check("sclk_srclk_exclusive", {31'd0, sclk & srclk}, 32'd0);
         if (frame_done) begin
            check("mon_dir", dir, exp_pub[7:4]);
            check("mon_chan", chan, exp_pub[11:8]);
`ifdef ISO_SERIAL_FLAG_FILTER_EN
            if (exp_pub[3:0] == hist) hw_exp = exp_pub[3:0];
            hist = exp_pub[3:0];
`else
            hw_exp = exp_pub[3:0];
`endif
            check("mon_hwflag", hwflag, hw_exp);
         end
      end
   end

   // ---------------- helpers
   task automatic wait_fd(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!frame_done && cycles < 300);
      if (!frame_done) begin
         vectors++;
         miscompares++;
         $display("FAIL frame_done_timeout: got none within %0d cycles", cycles);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sclk"}, sclk, 0);
      check({tag, "_srclk"}, srclk, 0);
      check({tag, "_cs_n_ser"}, cs_n_ser, 1);
      check({tag, "_hwcon_ser"}, hwcon_ser, 0);
      check({tag, "_dir"}, dir, 0);
      check({tag, "_chan"}, chan, 0);
      check({tag, "_hwflag"}, hwflag, 0);
      check({tag, "_frame_done"}, frame_done, 0);
   endtask

   typedef struct {
      logic [7:0] cs;
      logic [7:0] hw;
      logic [3:0] idir, ichan, iflag;
      logic [3:0] exp_slot_cs, exp_slot_hw, exp_dir, exp_chan, exp_flag;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int cyc;
      int n_sclk, n_srclk, n_fd;
      logic p_sclk, p_srclk;
      logic [3:0] exp_seq[6];
      logic [3:0] vset[6];
      logic [7:0] cur_cs, cur_hw;

      tbl[0] = '{8'hFE, 8'h05, 4'hA, 4'h3, 4'h9, 4'hE, 4'h5, 4'hA, 4'h3, 4'h9};
      tbl[1] = '{8'h35, 8'hCA, 4'h5, 4'hC, 4'h6, 4'h5, 4'hA, 4'h5, 4'hC, 4'h6};
      tbl[2] = '{8'hFF, 8'h00, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
      tbl[3] = '{8'h00, 8'hFF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};

      // reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_sclk", sclk, 0);
      check("idle_frame_done", frame_done, 0);

      // table vectors: three frames each, checked at the third
      for (int i = 0; i < 4; i++) begin
         cs_n_par  = tbl[i].cs;
         hwcon_par = tbl[i].hw;
         iso_dir   = tbl[i].idir;
         iso_chan  = tbl[i].ichan;
         iso_flag  = tbl[i].iflag;
         enable    = 1'b1;
         wait_fd(cyc);
         wait_fd(cyc);
         wait_fd(cyc);
         check($sformatf("tbl%0d_spacing", i), cyc, FRAME);
         check($sformatf("tbl%0d_slot_cs", i), lat_cs[3:0], tbl[i].exp_slot_cs);
         check($sformatf("tbl%0d_slot_hw", i), lat_hw[3:0], tbl[i].exp_slot_hw);
         check($sformatf("tbl%0d_dir", i), dir, tbl[i].exp_dir);
         check($sformatf("tbl%0d_chan", i), chan, tbl[i].exp_chan);
         check($sformatf("tbl%0d_hwflag", i), hwflag, tbl[i].exp_flag);
      end

      // enable dropped 10 cycles into SHIFT: frame still completes
      n_sclk = 0; n_srclk = 0; n_fd = 0;
      p_sclk = sclk; p_srclk = srclk;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (n == D + 9) enable = 1'b0;
         if (sclk && !p_sclk) n_sclk++;
         if (srclk && !p_srclk) n_srclk++;
         if (frame_done) n_fd++;
         p_sclk = sclk;
         p_srclk = srclk;
      end
      check("drop_sclk_edges", n_sclk, 8);
      check("drop_srclk_pulses", n_srclk, 1);
      check("drop_frame_done", n_fd, 1);
      check("drop_idle_sclk", sclk, 0);
      check("drop_idle_srclk", srclk, 0);

      // reset in LATCH, then hwflag filter sequence
      enable = 1'b1;
      wait_fd(cyc);
      iso_dir = 4'h6; iso_chan = 4'h9; iso_flag = 4'h2;
      cyc = 0;
      while (!srclk && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      check("latch_reached", srclk, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      vset = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h2, 4'h2};
`ifdef ISO_SERIAL_FLAG_FILTER_EN
      exp_seq = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
`else
      exp_seq = '{4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h2};
`endif
      iso_flag = vset[0];
      reset = 1'b0;
      wait_fd(cyc);
      check("release_to_frame_done", cyc, REL_TO_FD);
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) begin
            wait_fd(cyc);
            if (k == 2) check("post_reset_spacing", cyc, FRAME);
         end
         check($sformatf("flag_seq%0d", k), hwflag, exp_seq[k-1]);
         if (k < 6) iso_flag = vset[k];
      end

      // random frames; parallel inputs disturbed mid-frame must be ignored
      cur_cs = 8'($urandom);
      cur_hw = 8'($urandom);
      cs_n_par = cur_cs;
      hwcon_par = cur_hw;
      for (int r = 0; r < 10; r++) begin
         repeat (20) @(negedge clk);
         cs_n_par  = ~cur_cs;
         hwcon_par = ~cur_hw;
         iso_dir  = 4'($urandom);
         iso_chan = 4'($urandom);
         iso_flag = 4'($urandom_range(0, 3));
         wait_fd(cyc);
         check($sformatf("rnd%0d_latched_cs", r), lat_cs, cur_cs);
         check($sformatf("rnd%0d_latched_hw", r), lat_hw, cur_hw);
         cur_cs = 8'($urandom);
         cur_hw = 8'($urandom);
         cs_n_par = cur_cs;
         hwcon_par = cur_hw;
      end

      enable = 1'b0;
      repeat (2 * FRAME) @(negedge clk);
      check("final_idle_sclk", sclk, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
